piezo_phase_monitor: RTL and testbench

- Receive-side counterpart of the piezo controller: samples the driven or looped-back transducer lines and measures each channel's rising-edge phase within one drive period.
- Results go into a register file that the HPS reads over an Avalon-MM slave on the lightweight bridge.
- Used for closed-loop calibration of the levitation phase pattern.

---
 rtl/piezo_pkg.sv | 29 ++
 rtl/piezo_edge_sync.sv | 28 ++
 rtl/piezo_phase_monitor.sv | 167 ++++++++++++++++
 tb/tb_piezo_phase_monitor.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// piezo_pkg: shared defaults, Avalon register map, CTRL bit positions
// and FSM encoding for the piezo phase monitor.
package piezo_pkg;

  localparam int NUM_CH_DEF = 89;
  localparam int PERIOD_DEF = 1250;
  localparam int CNT_W_DEF  = 11;
  localparam int MISS_W     = 7;

  localparam logic [6:0] CTRL       = 7'h00;
  localparam logic [6:0] MISS       = 7'h01;
  localparam logic [6:0] PERIOD_REG = 7'h02;
  localparam logic [6:0] PHASE_BASE = 7'h20;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_ST_LO  = 2;
  localparam int CTRL_IRQ_EN = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/piezo_edge_sync.sv
// piezo_edge_sync: 2-flop synchronizer plus a third flop for a
// one-cycle rising-edge pulse. Ports: clk, reset_n, d (async), rise.
module piezo_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/piezo_phase_monitor.sv
// piezo_phase_monitor: per-channel rising-edge phase capture over one
// drive period, read back over Avalon-MM. Ports: clk, reset_n,
// piezo_in, period_start, avs_* slave, capture_done; irq when
// PIEZO_PHASE_MONITOR_IRQ_EN is defined.
module piezo_phase_monitor
  import piezo_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int PERIOD = PERIOD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] piezo_in,
  input  logic              period_start,
  input  logic [6:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              capture_done
`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [NUM_CH-1:0] rise;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    piezo_edge_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (piezo_in[i]),
      .rise    (rise[i])
    );
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  phase_q [NUM_CH];
  logic [CNT_W-1:0]  phase_d [NUM_CH];
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [31:0]       rd_q, rd_d;
  logic              done_q, done_d;
  logic              wr_ctrl, start, clr;
  logic [6:0]        ph_idx;
  logic              unused_wd;

  assign wr_ctrl   = avs_write && (avs_address == CTRL);
  assign start     = wr_ctrl && avs_writedata[CTRL_START];
  assign clr       = wr_ctrl && avs_writedata[CTRL_CLEAR];
  assign unused_wd = ^avs_writedata[31:2];

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (period_start || cnt_q == LAST) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    phase_d = phase_q;
    miss_d  = miss_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      // switch on the next counter value so CAPTURE opens at 0
      ARM:     if (cnt_d == '0) state_d = CAPTURE;
      CAPTURE: if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        if (start)    state_d = ARM;
        else if (clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q == CAPTURE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i] && !valid_q[i]) begin
          valid_d[i] = 1'b1;
          phase_d[i] = cnt_q;
        end
      end
    end
    // count from valid_d so a last-cycle edge is not a miss
    if (state_q == CAPTURE && state_d == DONE) begin
      miss_d = '0;
      for (int i = 0; i < NUM_CH; i++)
        miss_d = miss_d + MISS_W'(!valid_d[i]);
    end
    if (state_d == ARM && state_q != ARM) begin
      valid_d = '0;
      miss_d  = '0;
      for (int i = 0; i < NUM_CH; i++) phase_d[i] = '0;
    end
  end

  assign done_d = (state_d == DONE);

`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
  assign irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;
  assign irq_d    = done_q && irq_en_q && (state_d == DONE);
  assign irq      = irq_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`endif

  always_comb begin
    ph_idx = avs_address - PHASE_BASE;
    rd_d   = rd_q;
    if (avs_read) begin
      rd_d = '0;
      unique case (1'b1)
        (avs_address == CTRL): begin
          rd_d[CTRL_BUSY] = (state_q == ARM) || (state_q == CAPTURE);
          rd_d[CTRL_DONE] = (state_q == DONE);
          rd_d[CTRL_ST_LO +: 2] = state_q;
`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
          rd_d[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
        (avs_address == MISS): rd_d[MISS_W-1:0] = miss_q;
        (avs_address == PERIOD_REG): rd_d = 32'(PERIOD);
        (avs_address >= PHASE_BASE && int'(ph_idx) < NUM_CH): begin
          rd_d[31]        = valid_q[ph_idx];
          rd_d[CNT_W-1:0] = phase_q[ph_idx];
        end
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      miss_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

  assign avs_readdata = rd_q;
  assign capture_done = done_q;

endmodule

// File: tb/tb_piezo_phase_monitor.sv
// tb_piezo_phase_monitor: directed bench for piezo_phase_monitor.
// Tracks the phase counter locally from reset and period_start.
module tb_piezo_phase_monitor;

  localparam int NUM_CH = 89;
  localparam int PERIOD = 1250;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] piezo_in = '0;
  logic              period_start = 1'b0;
  logic [6:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              capture_done;
`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
  logic              irq;
`endif

  int compared = 0;
  int mismatched = 0;
  int bcnt = 0;
  logic [31:0] rd;

  piezo_phase_monitor dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .piezo_in      (piezo_in),
    .period_start  (period_start),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .capture_done  (capture_done)
`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (!reset_n || period_start || bcnt == PERIOD - 1) bcnt = 0;
    else bcnt++;
    #1;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (bcnt != v && n < 2 * PERIOD) begin
      tick();
      n++;
    end
    if (bcnt != v) begin
      compared++;
      mismatched++;
      $display("FAIL wait_cnt: counter %0d want %0d", bcnt, v);
    end
  endtask

  task automatic av_write(input logic [6:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic av_read(input logic [6:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset();
    logic [6:0] addrs [5];
    addrs = '{7'h00, 7'h01, 7'h20, 7'h4C, 7'h78};
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    compared++;
    if (capture_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_done: got %b want 0", capture_done);
    end
    compared++;
    if (avs_readdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_rdata: got %h want 0", avs_readdata);
    end
    for (int i = 0; i < 5; i++) begin
      av_read(addrs[i], rd);
      compared++;
      if (rd !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_reg %h: got %h want 0", addrs[i], rd);
      end
    end
    av_read(7'h02, rd);
    compared++;
    if (rd !== 32'd1250) begin
      mismatched++;
      $display("FAIL period_reg: got %h want %h", rd, 32'd1250);
    end
    av_read(7'h7F, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL unmapped: got %h want 0", rd);
    end
  endtask

  task automatic test_basic();
    av_write(7'h00, 32'h1);
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL ctrl_arm: got %h want 5", rd);
    end
    wait_cnt(0);
    av_write(7'h00, 32'h1);
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'h9) begin
      mismatched++;
      $display("FAIL start_in_capture: got %h want 9", rd);
    end
    wait_cnt(100);
    piezo_in[0] = 1'b1;
    wait_cnt(1000);
    piezo_in[88] = 1'b1;
    wait_cnt(PERIOD - 1);
    compared++;
    if (capture_done !== 1'b0) begin
      mismatched++;
      $display("FAIL done_early: got %b want 0", capture_done);
    end
    tick();
    compared++;
    if (capture_done !== 1'b1) begin
      mismatched++;
      $display("FAIL done_rise: got %b want 1", capture_done);
    end
    av_read(7'h20, rd);
    compared++;
    if (rd !== 32'h8000_0066) begin
      mismatched++;
      $display("FAIL basic_ch0: got %h want 80000066", rd);
    end
    av_read(7'h20 + 7'd88, rd);
    compared++;
    if (rd !== 32'h8000_03EA) begin
      mismatched++;
      $display("FAIL basic_ch88: got %h want 800003ea", rd);
    end
    av_read(7'h21, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL basic_ch1: got %h want 0", rd);
    end
    av_read(7'h01, rd);
    compared++;
    if (rd !== 32'd87) begin
      mismatched++;
      $display("FAIL basic_miss: got %0d want 87", rd);
    end
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'hE) begin
      mismatched++;
      $display("FAIL ctrl_done: got %h want e", rd);
    end
  endtask

  task automatic test_clear();
    avs_address = 7'h00;
    avs_writedata = 32'h2;
    avs_read = 1'b1;
    avs_write = 1'b1;
    tick();
    avs_read = 1'b0;
    avs_write = 1'b0;
    compared++;
    if (avs_readdata !== 32'hE) begin
      mismatched++;
      $display("FAIL rd_wr_same: got %h want e", avs_readdata);
    end
    compared++;
    if (capture_done !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_done: got %b want 0", capture_done);
    end
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL clear_ctrl: got %h want 0", rd);
    end
    av_read(7'h20, rd);
    compared++;
    if (rd !== 32'h8000_0066) begin
      mismatched++;
      $display("FAIL retain_ch0: got %h want 80000066", rd);
    end
  endtask

  task automatic test_repeat();
    piezo_in = '0;
    av_write(7'h00, 32'h1);
    av_read(7'h20, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL arm_clear_ch0: got %h want 0", rd);
    end
    wait_cnt(0);
    wait_cnt(50);
    piezo_in[5] = 1'b1;
    wait_cnt(350);
    piezo_in[5] = 1'b0;
    wait_cnt(650);
    piezo_in[5] = 1'b1;
    wait_cnt(950);
    piezo_in[5] = 1'b0;
    wait_cnt(PERIOD - 1);
    tick();
    av_read(7'h25, rd);
    compared++;
    if (rd !== 32'h8000_0034) begin
      mismatched++;
      $display("FAIL repeat_ch5: got %h want 80000034", rd);
    end
    av_read(7'h01, rd);
    compared++;
    if (rd !== 32'd88) begin
      mismatched++;
      $display("FAIL repeat_miss: got %0d want 88", rd);
    end
  endtask

  task automatic test_rearm();
    av_write(7'h00, 32'h1);
    compared++;
    if (capture_done !== 1'b0) begin
      mismatched++;
      $display("FAIL rearm_done: got %b want 0", capture_done);
    end
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL rearm_ctrl: got %h want 5", rd);
    end
    av_read(7'h25, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL rearm_ch5: got %h want 0", rd);
    end
  endtask

  task automatic test_window();
    wait_cnt(PERIOD - 2);
    piezo_in[10] = 1'b1;
    wait_cnt(0);
    wait_cnt(PERIOD - 3);
    piezo_in[30] = 1'b1;
    tick();
    piezo_in[20] = 1'b1;
    wait_cnt(PERIOD - 1);
    repeat (4) tick();
    av_read(7'h2A, rd);
    compared++;
    if (rd !== 32'h8000_0000) begin
      mismatched++;
      $display("FAIL win_first: got %h want 80000000", rd);
    end
    av_read(7'h34, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL win_late: got %h want 0", rd);
    end
    av_read(7'h3E, rd);
    compared++;
    if (rd !== 32'h8000_04E1) begin
      mismatched++;
      $display("FAIL win_last: got %h want 800004e1", rd);
    end
    av_read(7'h01, rd);
    compared++;
    if (rd !== 32'd87) begin
      mismatched++;
      $display("FAIL win_miss: got %0d want 87", rd);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    av_write(7'h00, 32'h2);
    piezo_in = '0;
    av_write(7'h00, 32'h1);
    wait_cnt(0);
    wait_cnt(300);
    piezo_in[0] = 1'b1;
    wait_cnt(600);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    av_read(7'h00, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL midrst_ctrl: got %h want 0", rd);
    end
    av_read(7'h20, rd);
    compared++;
    if (rd !== 32'h0) begin
      mismatched++;
      $display("FAIL midrst_ch0: got %h want 0", rd);
    end
    for (int i = 0; i < PERIOD + 20; i++) begin
      tick();
      if (capture_done) seen++;
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL midrst_done: high %0d cycles want 0", seen);
    end
  endtask

`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
  task automatic test_irq();
    av_write(7'h00, 32'h11);
    wait_cnt(0);
    wait_cnt(PERIOD - 1);
    tick();
    compared++;
    if (capture_done !== 1'b1 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_lag: got %b%b want 10", capture_done, irq);
    end
    tick();
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    av_write(7'h00, 32'h12);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_repeat();
    test_rearm();
    test_window();
    test_reset_mid();
`ifdef PIEZO_PHASE_MONITOR_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
